// File: rtl/qpu_lsu_mt_ctrl_if.sv
// ---------------------------------------------------------------------------
// qpu_lsu_mt_ctrl_if
// Bundles the LSU-facing ICB command / write-back channel and the per-target
// downstream ICB command / response channels of the LSU multi-target
// controller.
//   slave  : the controller's view (takes LSU commands, drives targets)
//   master : the environment's view (drives LSU commands, models targets)
// Port summary (signal / width):
//   lsu_icb_cmd_valid/ready 1, lsu_icb_cmd_addr 32, lsu_icb_cmd_read 1,
//   lsu_icb_cmd_wdata XLEN, lsu_icb_cmd_wmask XLEN/8,
//   lsu_o_valid/ready 1, lsu_o_wbck_wdat XLEN, lsu_o_cmt_badaddr 32,
//   lsu_o_cmt_ld 1, lsu_o_err 1,
//   tgt_icb_cmd_valid/ready NTGT, tgt_icb_cmd_addr 32, tgt_icb_cmd_read 1,
//   tgt_icb_cmd_wdata XLEN, tgt_icb_cmd_wmask XLEN/8,
//   tgt_icb_rsp_valid/ready NTGT, tgt_icb_rsp_rdata NTGT*XLEN,
//   tgt_icb_rsp_err NTGT, lsu_ctrl_active 1
// ---------------------------------------------------------------------------
interface qpu_lsu_mt_ctrl_if #(
    parameter int XLEN = 32,
    parameter int NTGT = 2
);
    // LSU command channel
    logic                   lsu_icb_cmd_valid;
    logic                   lsu_icb_cmd_ready;
    logic [31:0]            lsu_icb_cmd_addr;
    logic                   lsu_icb_cmd_read;
    logic [XLEN-1:0]        lsu_icb_cmd_wdata;
    logic [XLEN/8-1:0]      lsu_icb_cmd_wmask;
    // LSU write-back channel
    logic                   lsu_o_valid;
    logic                   lsu_o_ready;
    logic [XLEN-1:0]        lsu_o_wbck_wdat;
    logic [31:0]            lsu_o_cmt_badaddr;
    logic                   lsu_o_cmt_ld;
    logic                   lsu_o_err;
    // Downstream target command channels
    logic [NTGT-1:0]        tgt_icb_cmd_valid;
    logic [NTGT-1:0]        tgt_icb_cmd_ready;
    logic [31:0]            tgt_icb_cmd_addr;
    logic                   tgt_icb_cmd_read;
    logic [XLEN-1:0]        tgt_icb_cmd_wdata;
    logic [XLEN/8-1:0]      tgt_icb_cmd_wmask;
    // Downstream target response channels
    logic [NTGT-1:0]        tgt_icb_rsp_valid;
    logic [NTGT-1:0]        tgt_icb_rsp_ready;
    logic [NTGT*XLEN-1:0]   tgt_icb_rsp_rdata;
    logic [NTGT-1:0]        tgt_icb_rsp_err;
    // Status
    logic                   lsu_ctrl_active;

    modport slave (
        input  lsu_icb_cmd_valid, lsu_icb_cmd_addr, lsu_icb_cmd_read,
               lsu_icb_cmd_wdata, lsu_icb_cmd_wmask, lsu_o_ready,
               tgt_icb_cmd_ready, tgt_icb_rsp_valid, tgt_icb_rsp_rdata,
               tgt_icb_rsp_err,
        output lsu_icb_cmd_ready, lsu_o_valid, lsu_o_wbck_wdat,
               lsu_o_cmt_badaddr, lsu_o_cmt_ld, lsu_o_err,
               tgt_icb_cmd_valid, tgt_icb_cmd_addr, tgt_icb_cmd_read,
               tgt_icb_cmd_wdata, tgt_icb_cmd_wmask, tgt_icb_rsp_ready,
               lsu_ctrl_active
    );

    modport master (
        output lsu_icb_cmd_valid, lsu_icb_cmd_addr, lsu_icb_cmd_read,
               lsu_icb_cmd_wdata, lsu_icb_cmd_wmask, lsu_o_ready,
               tgt_icb_cmd_ready, tgt_icb_rsp_valid, tgt_icb_rsp_rdata,
               tgt_icb_rsp_err,
        input  lsu_icb_cmd_ready, lsu_o_valid, lsu_o_wbck_wdat,
               lsu_o_cmt_badaddr, lsu_o_cmt_ld, lsu_o_err,
               tgt_icb_cmd_valid, tgt_icb_cmd_addr, tgt_icb_cmd_read,
               tgt_icb_cmd_wdata, tgt_icb_cmd_wmask, tgt_icb_rsp_ready,
               lsu_ctrl_active
    );
endinterface

// File: rtl/qpu_lsu_mt_ctrl.sv
// ---------------------------------------------------------------------------
// qpu_lsu_mt_ctrl
// Routes LSU ICB commands to one of NTGT downstream ICB targets by address
// decode and returns responses to the LSU strictly in command order.
// An outstanding-command FIFO records {target, local error, read, addr} for
// every accepted command; its head selects which target response is
// forwarded to write-back. Commands that decode to no target (or are
// misaligned) are never sent downstream and are answered locally with an
// error from the FIFO head.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - qpu_lsu_mt_ctrl_if.slave (LSU command/write-back, target cmd/rsp)
// ---------------------------------------------------------------------------
module qpu_lsu_mt_ctrl #(
    parameter int                 XLEN     = 32,
    parameter int                 NTGT     = 2,
    parameter int                 OUTS_NUM = 2,
    parameter logic [NTGT*32-1:0] TGT_BASE = {32'h8000_0000, 32'h0000_0000},
    parameter logic [NTGT*32-1:0] TGT_MASK = {32'hFFFF_0000, 32'hFFFF_0000}
) (
    input  logic                  clk,
    input  logic                  rst,
    qpu_lsu_mt_ctrl_if.slave      bus
);

    localparam int TW = (NTGT > 1)     ? $clog2(NTGT)     : 1;
    localparam int PW = (OUTS_NUM > 1) ? $clog2(OUTS_NUM) : 1;
    localparam int CW = $clog2(OUTS_NUM + 1);

    // FIFO state
    logic [CW-1:0]   cnt_q,      cnt_d;
    logic [PW-1:0]   wptr_q,     wptr_d;
    logic [PW-1:0]   rptr_q,     rptr_d;
    logic [TW-1:0]   last_tgt_q, last_tgt_d;
    logic [TW-1:0]   fifo_tgt_q  [OUTS_NUM];
    logic [TW-1:0]   fifo_tgt_d  [OUTS_NUM];
    logic            fifo_err_q  [OUTS_NUM];
    logic            fifo_err_d  [OUTS_NUM];
    logic            fifo_read_q [OUTS_NUM];
    logic            fifo_read_d [OUTS_NUM];
    logic [31:0]     fifo_addr_q [OUTS_NUM];
    logic [31:0]     fifo_addr_d [OUTS_NUM];

    // Combinational decode / handshake
    logic            dec_hit_s;
    logic [TW-1:0]   dec_tgt_s;
    logic            misalign_s;
    logic            local_err_s;
    logic            full_s;
    logic            empty_s;
    logic            order_ok_s;
    logic            tgt_rdy_sel_s;
    logic            cmd_ready_s;
    logic            push_s;
    logic            pop_s;
    logic            o_valid_s;
    logic            o_err_s;

    // Head-of-FIFO view
    logic [TW-1:0]   h_tgt_s;
    logic            h_err_s;
    logic            h_read_s;
    logic [31:0]     h_addr_s;
    logic            rsp_valid_sel_s;
    logic            rsp_err_sel_s;
    logic [XLEN-1:0] rsp_rdata_sel_s;

    // Address decode: lowest-index matching target wins (scan high to low)
    always_comb begin
        dec_hit_s = 1'b0;
        dec_tgt_s = {TW{1'b0}};
        for (int i = NTGT - 1; i >= 0; i--) begin
            if ((bus.lsu_icb_cmd_addr & TGT_MASK[i*32 +: 32]) == TGT_BASE[i*32 +: 32]) begin
                dec_hit_s = 1'b1;
                dec_tgt_s = TW'(i);
            end else begin
                dec_hit_s = dec_hit_s;
            end
        end
        if (XLEN == 32) begin
            misalign_s = (bus.lsu_icb_cmd_addr[1:0] != 2'b00);
        end else begin
            misalign_s = 1'b0;
        end
        local_err_s = ~dec_hit_s | misalign_s;
    end

    // Command-side acceptance; ready depends only on registered occupancy
    // so a same-cycle pop never frees a slot for a push.
    always_comb begin
        full_s        = (cnt_q == CW'(OUTS_NUM));
        empty_s       = (cnt_q == {CW{1'b0}});
        order_ok_s    = empty_s | (dec_tgt_s == last_tgt_q);
        tgt_rdy_sel_s = 1'b0;
        for (int i = 0; i < NTGT; i++) begin
            if (dec_tgt_s == TW'(i)) begin
                tgt_rdy_sel_s = bus.tgt_icb_cmd_ready[i];
            end else begin
                tgt_rdy_sel_s = tgt_rdy_sel_s;
            end
        end
        cmd_ready_s = ~full_s & order_ok_s & (local_err_s | tgt_rdy_sel_s);
        push_s      = bus.lsu_icb_cmd_valid & cmd_ready_s;
    end

    // Head entry and the response of the target it is waiting on
    always_comb begin
        h_tgt_s         = fifo_tgt_q[rptr_q];
        h_err_s         = fifo_err_q[rptr_q];
        h_read_s        = fifo_read_q[rptr_q];
        h_addr_s        = fifo_addr_q[rptr_q];
        rsp_valid_sel_s = 1'b0;
        rsp_err_sel_s   = 1'b0;
        rsp_rdata_sel_s = {XLEN{1'b0}};
        for (int i = 0; i < NTGT; i++) begin
            if (h_tgt_s == TW'(i)) begin
                rsp_valid_sel_s = bus.tgt_icb_rsp_valid[i];
                rsp_err_sel_s   = bus.tgt_icb_rsp_err[i];
                rsp_rdata_sel_s = bus.tgt_icb_rsp_rdata[i*XLEN +: XLEN];
            end else begin
                rsp_valid_sel_s = rsp_valid_sel_s;
            end
        end
        o_valid_s = ~empty_s & (h_err_s | rsp_valid_sel_s);
        o_err_s   = ~empty_s & (h_err_s | rsp_err_sel_s);
        pop_s     = o_valid_s & bus.lsu_o_ready;
    end

    // Interface outputs
    always_comb begin
        bus.lsu_icb_cmd_ready = cmd_ready_s;
        bus.tgt_icb_cmd_addr  = bus.lsu_icb_cmd_addr;
        bus.tgt_icb_cmd_read  = bus.lsu_icb_cmd_read;
        bus.tgt_icb_cmd_wdata = bus.lsu_icb_cmd_wdata;
        bus.tgt_icb_cmd_wmask = bus.lsu_icb_cmd_wmask;
        bus.tgt_icb_cmd_valid = {NTGT{1'b0}};
        bus.tgt_icb_rsp_ready = {NTGT{1'b0}};
        for (int i = 0; i < NTGT; i++) begin
            if (dec_tgt_s == TW'(i)) begin
                bus.tgt_icb_cmd_valid[i] = bus.lsu_icb_cmd_valid & ~full_s & order_ok_s & ~local_err_s;
            end else begin
                bus.tgt_icb_cmd_valid[i] = 1'b0;
            end
            // Only the head's target may hand over a response; others stall.
            if (h_tgt_s == TW'(i)) begin
                bus.tgt_icb_rsp_ready[i] = ~empty_s & bus.lsu_o_ready & ~h_err_s;
            end else begin
                bus.tgt_icb_rsp_ready[i] = 1'b0;
            end
        end
        bus.lsu_o_valid       = o_valid_s;
        bus.lsu_o_err         = o_err_s;
        bus.lsu_o_wbck_wdat   = (o_valid_s & ~o_err_s) ? rsp_rdata_sel_s : {XLEN{1'b0}};
        bus.lsu_o_cmt_badaddr = empty_s ? 32'h0000_0000 : h_addr_s;
        bus.lsu_o_cmt_ld      = ~empty_s & h_read_s;
        bus.lsu_ctrl_active   = bus.lsu_icb_cmd_valid | ~empty_s;
    end

    // FIFO next state: wrap-around pointers and occupancy counter
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        cnt_d       = cnt_q;
        last_tgt_d  = last_tgt_q;
        fifo_tgt_d  = fifo_tgt_q;
        fifo_err_d  = fifo_err_q;
        fifo_read_d = fifo_read_q;
        fifo_addr_d = fifo_addr_q;
        if (push_s) begin
            fifo_tgt_d[wptr_q]  = dec_tgt_s;
            fifo_err_d[wptr_q]  = local_err_s;
            fifo_read_d[wptr_q] = bus.lsu_icb_cmd_read;
            fifo_addr_d[wptr_q] = bus.lsu_icb_cmd_addr;
            last_tgt_d          = dec_tgt_s;
            wptr_d = (wptr_q == PW'(OUTS_NUM - 1)) ? {PW{1'b0}} : wptr_q + PW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = (rptr_q == PW'(OUTS_NUM - 1)) ? {PW{1'b0}} : rptr_q + PW'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset empties the FIFO and forgets all outstanding work
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= {CW{1'b0}};
            wptr_q     <= {PW{1'b0}};
            rptr_q     <= {PW{1'b0}};
            last_tgt_q <= {TW{1'b0}};
            for (int i = 0; i < OUTS_NUM; i++) begin
                fifo_tgt_q[i]  <= {TW{1'b0}};
                fifo_err_q[i]  <= 1'b0;
                fifo_read_q[i] <= 1'b0;
                fifo_addr_q[i] <= 32'h0000_0000;
            end
        end else begin
            cnt_q       <= cnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            last_tgt_q  <= last_tgt_d;
            fifo_tgt_q  <= fifo_tgt_d;
            fifo_err_q  <= fifo_err_d;
            fifo_read_q <= fifo_read_d;
            fifo_addr_q <= fifo_addr_d;
        end
    end

endmodule

// File: tb/tb_qpu_lsu_mt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_qpu_lsu_mt_ctrl
// Directed bench for qpu_lsu_mt_ctrl with default parameters (two targets:
// target 0 at 0x0000_xxxx, target 1 at 0x8000_xxxx, FIFO depth 2).
// Inputs change 1 ns after the rising edge, outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_qpu_lsu_mt_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    qpu_lsu_mt_ctrl_if #(.XLEN(32), .NTGT(2)) bus ();

    qpu_lsu_mt_ctrl #(.XLEN(32), .NTGT(2), .OUTS_NUM(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic v, input logic [31:0] a, input logic rd);
        bus.lsu_icb_cmd_valid = v;
        bus.lsu_icb_cmd_addr  = a;
        bus.lsu_icb_cmd_read  = rd;
    endtask

    task automatic rsp(input logic [1:0] v, input logic [1:0] e,
                       input logic [31:0] d1, input logic [31:0] d0);
        bus.tgt_icb_rsp_valid = v;
        bus.tgt_icb_rsp_err   = e;
        bus.tgt_icb_rsp_rdata = {d1, d0};
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        cmd(1'b0, 32'h0000_0000, 1'b0);
        bus.lsu_icb_cmd_wdata = 32'h0000_0000;
        bus.lsu_icb_cmd_wmask = 4'h0;
        bus.lsu_o_ready       = 1'b0;
        bus.tgt_icb_cmd_ready = 2'b00;
        rsp(2'b00, 2'b00, 32'h0, 32'h0);
        #2;
        // Reset state
        check_eq("rst_cmd_ready", bus.lsu_icb_cmd_ready, 1'b0);
        check_eq("rst_o_valid",   bus.lsu_o_valid, 1'b0);
        check_eq("rst_active",    bus.lsu_ctrl_active, 1'b0);
        check_eq("rst_tgt_valid", bus.tgt_icb_cmd_valid, 2'b00);
        check_eq("rst_rsp_ready", bus.tgt_icb_rsp_ready, 2'b00);
        check_eq("rst_badaddr",   bus.lsu_o_cmt_badaddr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.tgt_icb_cmd_ready = 2'b11;

        // Load 0x10 to target 0, response one cycle later
        cmd(1'b1, 32'h0000_0010, 1'b1);
        #1;
        check_eq("ld_cmd_ready", bus.lsu_icb_cmd_ready, 1'b1);
        check_eq("ld_tgt_valid", bus.tgt_icb_cmd_valid, 2'b01);
        check_eq("ld_tgt_addr",  bus.tgt_icb_cmd_addr, 32'h0000_0010);
        tick();
        cmd(1'b0, 32'h0, 1'b0);
        #1;
        check_eq("ld_wait_valid",  bus.lsu_o_valid, 1'b0);
        check_eq("ld_wait_active", bus.lsu_ctrl_active, 1'b1);
        rsp(2'b01, 2'b00, 32'h0, 32'hDEAD_BEEF);
        bus.lsu_o_ready = 1'b1;
        #1;
        check_eq("ld_o_valid",   bus.lsu_o_valid, 1'b1);
        check_eq("ld_wdat",      bus.lsu_o_wbck_wdat, 32'hDEAD_BEEF);
        check_eq("ld_cmt_ld",    bus.lsu_o_cmt_ld, 1'b1);
        check_eq("ld_err",       bus.lsu_o_err, 1'b0);
        check_eq("ld_badaddr",   bus.lsu_o_cmt_badaddr, 32'h0000_0010);
        check_eq("ld_rsp_ready", bus.tgt_icb_rsp_ready, 2'b01);
        tick();
        rsp(2'b00, 2'b00, 32'h0, 32'h0);
        #1;
        check_eq("ld_done_active", bus.lsu_ctrl_active, 1'b0);

        // Store to target 1 blocked behind an outstanding target-0 load
        cmd(1'b1, 32'h0000_0010, 1'b1);
        #1;
        check_eq("ord_ld_ready", bus.lsu_icb_cmd_ready, 1'b1);
        tick();
        cmd(1'b1, 32'h8000_0004, 1'b0);
        bus.lsu_icb_cmd_wdata = 32'hCAFE_F00D;
        bus.lsu_icb_cmd_wmask = 4'hF;
        #1;
        check_eq("ord_st_blocked",   bus.lsu_icb_cmd_ready, 1'b0);
        check_eq("ord_st_tgt_valid", bus.tgt_icb_cmd_valid, 2'b00);
        tick();
        rsp(2'b01, 2'b00, 32'h0, 32'h1234_5678);
        #1;
        check_eq("ord_pop_valid",   bus.lsu_o_valid, 1'b1);
        check_eq("ord_pop_blocked", bus.lsu_icb_cmd_ready, 1'b0);
        tick();
        rsp(2'b00, 2'b00, 32'h0, 32'h0);
        #1;
        check_eq("ord_st_ready",     bus.lsu_icb_cmd_ready, 1'b1);
        check_eq("ord_st_tgt_valid1", bus.tgt_icb_cmd_valid, 2'b10);
        check_eq("ord_st_wdata",     bus.tgt_icb_cmd_wdata, 32'hCAFE_F00D);
        check_eq("ord_st_read",      bus.tgt_icb_cmd_read, 1'b0);
        tick();
        cmd(1'b0, 32'h0, 1'b0);
        // Target 1 reports a bus error on the store
        rsp(2'b10, 2'b10, 32'h5555_AAAA, 32'h0);
        #1;
        check_eq("st_err_valid",   bus.lsu_o_valid, 1'b1);
        check_eq("st_err_err",     bus.lsu_o_err, 1'b1);
        check_eq("st_err_cmt_ld",  bus.lsu_o_cmt_ld, 1'b0);
        check_eq("st_err_badaddr", bus.lsu_o_cmt_badaddr, 32'h8000_0004);
        check_eq("st_err_wdat",    bus.lsu_o_wbck_wdat, 32'h0);
        check_eq("st_err_rsp_rdy", bus.tgt_icb_rsp_ready, 2'b10);
        tick();
        rsp(2'b00, 2'b00, 32'h0, 32'h0);

        // Unmapped load answered locally with an error
        cmd(1'b1, 32'h4000_0000, 1'b1);
        #1;
        check_eq("nohit_ready",     bus.lsu_icb_cmd_ready, 1'b1);
        check_eq("nohit_tgt_valid", bus.tgt_icb_cmd_valid, 2'b00);
        check_eq("nohit_o_valid0",  bus.lsu_o_valid, 1'b0);
        tick();
        cmd(1'b0, 32'h0, 1'b0);
        #1;
        check_eq("nohit_o_valid",   bus.lsu_o_valid, 1'b1);
        check_eq("nohit_err",       bus.lsu_o_err, 1'b1);
        check_eq("nohit_badaddr",   bus.lsu_o_cmt_badaddr, 32'h4000_0000);
        check_eq("nohit_wdat",      bus.lsu_o_wbck_wdat, 32'h0);
        check_eq("nohit_rsp_ready", bus.tgt_icb_rsp_ready, 2'b00);
        tick();
        // Misaligned load inside target 0 window is also a local error
        cmd(1'b1, 32'h0000_0012, 1'b1);
        #1;
        check_eq("misal_ready",     bus.lsu_icb_cmd_ready, 1'b1);
        check_eq("misal_tgt_valid", bus.tgt_icb_cmd_valid, 2'b00);
        tick();
        cmd(1'b0, 32'h0, 1'b0);
        #1;
        check_eq("misal_err",     bus.lsu_o_err, 1'b1);
        check_eq("misal_badaddr", bus.lsu_o_cmt_badaddr, 32'h0000_0012);
        tick();
        check_eq("misal_active",  bus.lsu_ctrl_active, 1'b0);

        // Three back-to-back loads with responses held off: third stalls
        bus.lsu_o_ready = 1'b0;
        cmd(1'b1, 32'h0000_0100, 1'b1);
        #1;
        check_eq("full_a_ready", bus.lsu_icb_cmd_ready, 1'b1);
        tick();
        cmd(1'b1, 32'h0000_0104, 1'b1);
        #1;
        check_eq("full_b_ready", bus.lsu_icb_cmd_ready, 1'b1);
        tick();
        cmd(1'b1, 32'h0000_0108, 1'b1);
        #1;
        check_eq("full_c_stall",     bus.lsu_icb_cmd_ready, 1'b0);
        check_eq("full_c_tgt_valid", bus.tgt_icb_cmd_valid, 2'b00);
        tick();
        rsp(2'b01, 2'b00, 32'h0, 32'h1111_1111);
        bus.lsu_o_ready = 1'b1;
        #1;
        check_eq("full_pop_a_addr", bus.lsu_o_cmt_badaddr, 32'h0000_0100);
        check_eq("full_pop_a_wdat", bus.lsu_o_wbck_wdat, 32'h1111_1111);
        check_eq("full_pop_blocks", bus.lsu_icb_cmd_ready, 1'b0);
        tick();
        rsp(2'b01, 2'b00, 32'h0, 32'h2222_2222);
        #1;
        check_eq("full_pop_b_addr", bus.lsu_o_cmt_badaddr, 32'h0000_0104);
        check_eq("full_pop_b_wdat", bus.lsu_o_wbck_wdat, 32'h2222_2222);
        check_eq("full_c_ready",    bus.lsu_icb_cmd_ready, 1'b1);
        tick();
        cmd(1'b0, 32'h0, 1'b0);
        rsp(2'b01, 2'b00, 32'h0, 32'h3333_3333);
        #1;
        check_eq("full_pop_c_addr", bus.lsu_o_cmt_badaddr, 32'h0000_0108);
        check_eq("full_pop_c_wdat", bus.lsu_o_wbck_wdat, 32'h3333_3333);
        tick();
        rsp(2'b00, 2'b00, 32'h0, 32'h0);
        #1;
        check_eq("full_done_active", bus.lsu_ctrl_active, 1'b0);

        // Reset with two outstanding commands
        bus.lsu_o_ready = 1'b0;
        cmd(1'b1, 32'h0000_0200, 1'b1);
        tick();
        cmd(1'b1, 32'h0000_0204, 1'b1);
        tick();
        cmd(1'b0, 32'h0, 1'b0);
        rsp(2'b01, 2'b00, 32'h0, 32'h4444_4444);
        #1;
        check_eq("rst2_pre_valid",  bus.lsu_o_valid, 1'b1);
        check_eq("rst2_pre_active", bus.lsu_ctrl_active, 1'b1);
        rst = 1'b1;
        bus.lsu_o_ready = 1'b1;
        #1;
        check_eq("rst2_active",    bus.lsu_ctrl_active, 1'b0);
        check_eq("rst2_o_valid",   bus.lsu_o_valid, 1'b0);
        check_eq("rst2_rsp_ready", bus.tgt_icb_rsp_ready, 2'b00);
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst2_post_active",  bus.lsu_ctrl_active, 1'b0);
        check_eq("rst2_post_o_valid", bus.lsu_o_valid, 1'b0);
        check_eq("rst2_post_rsp_rdy", bus.tgt_icb_rsp_ready, 2'b00);
        tick();
        rsp(2'b00, 2'b00, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
